// File: rtl/jtag_tap_master.sv
// JTAG host sequencer: turns RESET/IR_SCAN/DR_SCAN/IDLE commands into tclk/tms/tdi waveforms.
// Latency: accept -> rsp_valid = N_tck * 2 * HALF_PERIOD clk cycles.
// Backpressure: single command in flight; cmd_ready low while busy, rsp_valid held until rsp_ready.
module jtag_tap_master #(
  parameter int HALF_PERIOD = 1,
  parameter int RESET_TCKS  = 5
) (
  input  logic        clk,
  input  logic        trst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        tclk,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo,
  input  logic        tdo_en
);

  typedef enum logic [2:0] {
    S_INIT, S_READY, S_HEADER, S_SHIFT, S_TRAILER, S_RESP
  } state_t;

  localparam logic [1:0] OP_RESET   = 2'd0;
  localparam logic [1:0] OP_IR      = 2'd1;
  localparam logic [1:0] OP_DR      = 2'd2;
  localparam logic [1:0] OP_IDLE    = 2'd3;
  localparam logic [7:0] PHASE_LAST = 8'(HALF_PERIOD - 1);
  localparam logic [5:0] RST_LAST   = 6'(RESET_TCKS);

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_idx, w_idx_nxt;
  logic [1:0]  r_op, w_op_nxt;
  logic [5:0]  r_len, w_len_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic [31:0] r_rsp, w_rsp_nxt;
  logic        r_tclk, w_tclk_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_tms, w_tms_nxt;
  logic        r_tdi, w_tdi_nxt;

  logic [5:0]  w_cmd_len;
  logic [5:0]  w_hdr_last;
  logic        w_phase_end;
  logic        w_shift_dat;

  // TMS level for TCK number idx of a given state; INIT and RESET share the reset pattern.
  function automatic logic f_tms(input state_t s, input logic [1:0] op,
                                 input logic [5:0] idx, input logic [5:0] len);
    logic m;
    m = 1'b0;
    case (s)
      S_INIT:    m = (idx < RST_LAST);
      S_HEADER: begin
        case (op)
          OP_RESET: m = (idx < RST_LAST);
          OP_IR:    m = (idx < 6'd2);
          default:  m = (idx == 6'd0);
        endcase
      end
      S_SHIFT:   m = (op != OP_IDLE) && (idx == len - 6'd1);
      S_TRAILER: m = (idx == 6'd0);
      default:   m = 1'b0;
    endcase
    return m;
  endfunction

  assign w_cmd_len   = (cmd_len == 5'd0) ? 6'd32 : {1'b0, cmd_len};
  assign w_hdr_last  = (r_op == OP_RESET) ? RST_LAST : (r_op == OP_IR) ? 6'd3 : 6'd2;
  assign w_phase_end = (r_cnt == PHASE_LAST);
  assign w_shift_dat = (r_state == S_SHIFT) && (r_op != OP_IDLE);

  // State and datapath registers; the reset state is already the low phase of the first INIT TCK.
  always_ff @(posedge clk or negedge trst) begin
    if (!trst) begin
      r_state <= S_INIT;
      r_idx   <= '0;
      r_op    <= OP_RESET;
      r_len   <= '0;
      r_data  <= '0;
      r_rsp   <= '0;
      r_tclk  <= 1'b0;
      r_cnt   <= '0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_op    <= w_op_nxt;
      r_len   <= w_len_nxt;
      r_data  <= w_data_nxt;
      r_rsp   <= w_rsp_nxt;
      r_tclk  <= w_tclk_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tms   <= w_tms_nxt;
      r_tdi   <= w_tdi_nxt;
    end
  end

  // Next-state: tclk phase timing, tdo capture on rising tclk, next TCK set-up on falling tclk.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_op_nxt    = r_op;
    w_len_nxt   = r_len;
    w_data_nxt  = r_data;
    w_rsp_nxt   = r_rsp;
    w_tclk_nxt  = r_tclk;
    w_cnt_nxt   = r_cnt;
    w_tms_nxt   = r_tms;
    w_tdi_nxt   = r_tdi;
    case (r_state)
      S_READY: begin
        if (cmd_valid) begin
          w_state_nxt = (cmd_op == OP_IDLE) ? S_SHIFT : S_HEADER;
          w_idx_nxt   = '0;
          w_op_nxt    = cmd_op;
          w_len_nxt   = w_cmd_len;
          w_data_nxt  = cmd_data;
          w_rsp_nxt   = '0;
          w_cnt_nxt   = '0;
          w_tclk_nxt  = 1'b0;
          // The first TCK is never a data-carrying shift, so tdi starts low.
          w_tms_nxt   = f_tms(w_state_nxt, cmd_op, 6'd0, w_cmd_len);
          w_tdi_nxt   = 1'b0;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_READY;
      end
      default: begin
        if (w_phase_end) begin
          w_cnt_nxt  = '0;
          w_tclk_nxt = ~r_tclk;
        end else begin
          w_cnt_nxt  = r_cnt + 8'd1;
        end
        if (w_phase_end && !r_tclk && w_shift_dat) begin
          w_rsp_nxt[r_idx[4:0]] = tdo & tdo_en;
        end
        if (w_phase_end && r_tclk) begin
          w_idx_nxt = r_idx + 6'd1;
          case (r_state)
            S_INIT: begin
              if (r_idx == RST_LAST) w_state_nxt = S_READY;
            end
            S_HEADER: begin
              if (r_idx == w_hdr_last) begin
                w_state_nxt = (r_op == OP_RESET) ? S_RESP : S_SHIFT;
                w_idx_nxt   = '0;
              end
            end
            S_SHIFT: begin
              if (r_idx == r_len - 6'd1) begin
                w_state_nxt = (r_op == OP_IDLE) ? S_RESP : S_TRAILER;
                w_idx_nxt   = '0;
              end
            end
            default: begin
              if (r_idx == 6'd1) w_state_nxt = S_RESP;
            end
          endcase
          if (w_state_nxt == S_READY || w_state_nxt == S_RESP) begin
            w_tms_nxt = 1'b0;
            w_tdi_nxt = 1'b0;
          end else begin
            w_tms_nxt = f_tms(w_state_nxt, r_op, w_idx_nxt, r_len);
            w_tdi_nxt = (w_state_nxt == S_SHIFT && r_op != OP_IDLE) ? r_data[w_idx_nxt[4:0]] : 1'b0;
          end
        end
      end
    endcase
  end

  assign cmd_ready = (r_state == S_READY);
  assign busy      = (r_state != S_READY);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_rsp;
  assign tclk      = r_tclk;
  assign tms       = r_tms;
  assign tdi       = r_tdi;

endmodule

// File: doc/jtag_tap_master.md
Name: jtag_tap_master

Overview:
- Clocked JTAG host sequencer that drives a TAP such as dtm_jtag from a simple command/response interface.
- Generates tclk/tms/tdi, tracks a mirror of the TAP state, shifts IR/DR scans LSB-first and returns captured tdo bits.
- Sits between the on-chip test/boot controller and the debug transport module. Replaces hand-written TMS sequencing in benches and firmware.

Parameters:
- HALF_PERIOD, 1, clk cycles per tclk phase (low or high); legal range 1..255.
- RESET_TCKS, 5, number of TMS=1 TCKs in a reset sequence; legal range 5..15.

Ports:
- clk  in  1  system clock.
- trst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  operation: 0=RESET, 1=IR_SCAN, 2=DR_SCAN, 3=IDLE.
- cmd_len  in  5  bits to shift, or idle TCKs; 0 means 32.
- cmd_data  in  32  tdi bits; bit 0 is shifted first.
- rsp_valid  out  1  response available; held until taken.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_data  out  32  captured tdo, right-justified; bits >= len are 0.
- busy  out  1  sequence in progress.
- tclk  out  1  TAP clock.
- tms  out  1  TAP mode select.
- tdi  out  1  TAP data in.
- tdo  in  1  TAP data out.
- tdo_en  in  1  TAP output enable; captured bit = tdo & tdo_en.

Behaviour:
- Reset values (async while trst=0): tclk=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1.
- TCK cycle:
  - Low phase of HALF_PERIOD clks, then high phase of HALF_PERIOD clks.
  - tms/tdi change only on the clk edge where tclk goes 1->0, or at TCK start from idle.
  - tdo is sampled on the clk edge where tclk goes 0->1.
  - Idle level: tclk=0.
- After trst release, the automatic INIT sequence runs:
  - RESET_TCKS TCKs with TMS=1, then 1 TCK with TMS=0; mirror ends in Run-Test/Idle.
  - No response is produced.
  - Then cmd_ready=1 and busy=0.
- Every command starts and ends in Run-Test/Idle (mirror state).
- TMS sequences, len = effective length 1..32:
  - RESET: RESET_TCKS x TMS=1, then TMS=0. Total RESET_TCKS+1 TCKs.
  - IR_SCAN:
    - Header TMS 1,1,0,0 (SelDR, SelIR, CapIR, ShiftIR).
    - len shift TCKs: TMS=0 for the first len-1, TMS=1 on the last (Exit1-IR).
    - Trailer TMS 1,0 (Update-IR, RTI).
    - Total len+6 TCKs.
  - DR_SCAN:
    - Header TMS 1,0,0 (SelDR, CapDR, ShiftDR).
    - len shift TCKs with the same TMS rule as IR_SCAN.
    - Trailer TMS 1,0.
    - Total len+5 TCKs.
  - IDLE: len TCKs with TMS=0.
- Shift data:
  - During shift TCK i (0-based): tdi=cmd_data[i], and rsp_data[i] = sampled tdo.
  - Outside shift TCKs: tdi=0.
- FSM states: INIT, READY, HEADER, SHIFT, TRAILER, RESP.
  - READY -> HEADER on accept (IDLE op goes directly to SHIFT with TMS forced 0).
  - HEADER -> SHIFT after the header count.
  - SHIFT -> TRAILER after len TCKs.
  - TRAILER -> RESP when done. RESET op: HEADER carries the whole sequence, then RESP.
  - RESP -> READY on rsp handshake.
- Handshake:
  - cmd_ready=1 only in READY; command fields are latched on accept.
  - rsp_valid rises on the clk edge where tclk falls after the final TCK.
  - RESET and IDLE return rsp_data=0.
  - rsp_valid holds and rsp_data stays stable until rsp_ready.
  - Next cmd_ready rises the cycle after the rsp handshake.
- busy=1 in every state except READY.
- Latency: accept -> rsp_valid = N_tck * 2 * HALF_PERIOD clk cycles.
- Boundaries:
  - cmd_len=0 shifts 32 bits.
  - len=1: the single shift TCK has TMS=1.
  - rsp_ready held high: still exactly one handshake cycle.
  - cmd_valid while busy: ignored, no queueing.
  - trst asserted mid-scan: outputs revert immediately, the partial response is discarded, and INIT runs again after release.

Test Plan:
- Reset and INIT: pulse trst, HALF_PERIOD=1 -> tms=1 for 5 tclk rising edges, then tms=0 for 1 edge; cmd_ready=1 at clk 12 after release; TAP model in Run-Test/Idle.
- IDCODE read: DR_SCAN len=0 (32) against a TAP model with IDCODE 0x1BEEF001 -> 37 tclk rises; rsp_data=0x1BEEF001; model passes Capture-DR, 32x Shift-DR, Exit1-DR, Update-DR, RTI.
- BYPASS: IR_SCAN len=5, data=0x1F -> 11 TCKs, IR=0x1F. Then DR_SCAN len=8, data=0x01 -> rsp_data=0x02 (1-bit bypass delay).
- tdo_en gating: DR_SCAN len=4 with tdo=1 and tdo_en=0 on bits 1,3 -> rsp_data=0x5.
- Backpressure and edges:
  - IDLE len=3 with rsp_ready=0 for 10 clks -> rsp_valid held, rsp_data=0, cmd_ready=0 throughout.
  - DR_SCAN len=1 -> the single shift TCK has tms=1.
- Reset mid-scan: assert trst during shift bit 10 of a DR_SCAN -> tclk=0, tms=1, rsp_valid=0 immediately; no response; INIT repeats after release.
